// File: rtl/score_keeper.sv
// Game-score accumulator: saturating binary score, BCD image drained one count per cycle,
// spawn speed level. Optional high-score register enabled by SCORE_HISCORE_EN.
module score_keeper #(
  parameter int unsigned N_WAVE   = 5,
  parameter int unsigned WAVE_PTS = 1,
  parameter int unsigned ROAM_PTS = 5,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PEND_W   = 8,
  parameter int unsigned TH1      = 100,
  parameter int unsigned TH2      = 500,
  parameter int unsigned TH3      = 1000,
  parameter int unsigned TH4      = 5000,
  localparam int unsigned MAX_SCORE = 10 ** DIGITS - 1,
  localparam int unsigned SCORE_W   = $clog2(MAX_SCORE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [N_WAVE-1:0]     hit_w_enemy,
  input  logic                  hit_r_enemy,
  output logic [SCORE_W-1:0]    score_bin,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic                  busy,
  output logic                  sat,
  output logic [2:0]            speed_level,
  output logic [4*DIGITS-1:0]   hiscore_bcd
);

  localparam int unsigned PTS_MAX = N_WAVE * WAVE_PTS + ROAM_PTS;
  localparam int unsigned PTS_W   = $clog2(PTS_MAX + 1);
  localparam int unsigned SUM_W   = ((PEND_W > PTS_W) ? PEND_W : PTS_W) + 1;

  localparam logic [SCORE_W-1:0]  MaxScoreV = SCORE_W'(MAX_SCORE);
  localparam logic [SCORE_W:0]    MaxWide   = (SCORE_W + 1)'(MAX_SCORE);
  localparam logic [SUM_W-1:0]    PendMax   = SUM_W'((2 ** PEND_W) - 1);
  localparam logic [4*DIGITS-1:0] AllNines  = {DIGITS{4'h9}};
  localparam logic [SCORE_W-1:0]  Th1V      = SCORE_W'(TH1);
  localparam logic [SCORE_W-1:0]  Th2V      = SCORE_W'(TH2);
  localparam logic [SCORE_W-1:0]  Th3V      = SCORE_W'(TH3);
  localparam logic [SCORE_W-1:0]  Th4V      = SCORE_W'(TH4);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StCount = 2'd1;
  localparam logic [1:0] StSat   = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [4*DIGITS-1:0]  bcd_q, bcd_d, bcd_inc;
  logic [PEND_W-1:0]    pend_q, pend_d, pend_sat;
  logic [SUM_W-1:0]     pend_sum;
  logic                 busy_q, sat_q, sat_d;
  logic [2:0]           speed_q, speed_d;
  logic [PTS_W-1:0]     pts;
  logic [SCORE_W:0]     bin_sum;
  logic                 carry;

  always_comb begin
    pts = '0;
    for (int unsigned i = 0; i < N_WAVE; i++) begin
      if (hit_w_enemy[i]) pts = pts + PTS_W'(WAVE_PTS);
    end
    if (hit_r_enemy) pts = pts + PTS_W'(ROAM_PTS);
  end

  always_comb begin
    bin_sum = {1'b0, score_q} + (SCORE_W + 1)'(pts);
    score_d = (bin_sum >= MaxWide) ? MaxScoreV : bin_sum[SCORE_W-1:0];
    sat_d   = sat_q | (score_d == MaxScoreV);
  end

  // Ripple BCD +1: a digit wraps 9->0 and passes the carry upward.
  always_comb begin
    bcd_inc = bcd_q;
    carry   = 1'b1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (bcd_q[4*d +: 4] == 4'd9) begin
          bcd_inc[4*d +: 4] = 4'd0;
        end else begin
          bcd_inc[4*d +: 4] = bcd_q[4*d +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_comb begin
    pend_sum = SUM_W'(pend_q) + SUM_W'(pts) - SUM_W'(state_q == StCount);
    pend_sat = (pend_sum > PendMax) ? '1 : pend_sum[PEND_W-1:0];
  end

  // Entry into COUNT uses the next pending value so the drain starts right after the hit.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    bcd_d   = bcd_q;
    case (state_q)
      StIdle: begin
        pend_d = pend_sat;
        if (pend_d != '0) state_d = StCount;
      end
      StCount: begin
        bcd_d = bcd_inc;
        if (bcd_inc == AllNines) begin
          state_d = StSat;
          pend_d  = '0;
        end else begin
          pend_d = pend_sat;
          if (pend_d == '0) state_d = StIdle;
        end
      end
      StSat: begin
        pend_d = '0;
      end
      default: begin
        state_d = StIdle;
        pend_d  = '0;
      end
    endcase
  end

  always_comb begin
    if (score_q < Th1V)      speed_d = 3'd5;
    else if (score_q < Th2V) speed_d = 3'd4;
    else if (score_q < Th3V) speed_d = 3'd3;
    else if (score_q < Th4V) speed_d = 3'd2;
    else                     speed_d = 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= StIdle;
      score_q <= '0;
      bcd_q   <= '0;
      pend_q  <= '0;
      busy_q  <= 1'b0;
      sat_q   <= 1'b0;
      speed_q <= 3'd5;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      bcd_q   <= bcd_d;
      pend_q  <= pend_d;
      busy_q  <= (pend_d != '0);
      sat_q   <= sat_d;
      speed_q <= speed_d;
    end
  end

`ifdef SCORE_HISCORE_EN
  logic [4*DIGITS-1:0] hi_q;

  // Packed BCD with valid digits orders the same as an unsigned binary compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
    end else if (!busy_q && (bcd_q > hi_q)) begin
      hi_q <= bcd_q;
    end
  end

  assign hiscore_bcd = hi_q;
`else
  assign hiscore_bcd = '0;
`endif

  assign score_bin   = score_q;
  assign score_bcd   = bcd_q;
  assign busy        = busy_q;
  assign sat         = sat_q;
  assign speed_level = speed_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: table of single-hit vectors plus hand-written
// sequences for drain timing, reset abort, speed thresholds, saturation and high score.
module tb_score_keeper;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [4:0]  hit_w_enemy;
  logic        hit_r_enemy;
  logic [13:0] score_bin;
  logic [15:0] score_bcd;
  logic        busy;
  logic        sat;
  logic [2:0]  speed_level;
  logic [15:0] hiscore_bcd;

  int checks;
  int failures;

  score_keeper dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .hit_w_enemy (hit_w_enemy),
    .hit_r_enemy (hit_r_enemy),
    .score_bin   (score_bin),
    .score_bcd   (score_bcd),
    .busy        (busy),
    .sat         (sat),
    .speed_level (speed_level),
    .hiscore_bcd (hiscore_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  w;
    logic        r;
    int          exp_bin;
    logic [15:0] exp_bcd;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hit_cycle(input logic [4:0] w, input logic r);
    hit_w_enemy = w;
    hit_r_enemy = r;
    step();
    hit_w_enemy = '0;
    hit_r_enemy = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL wait_idle busy still 1 after %0d cycles, required 0", budget);
    end
  endtask

  // Feeds n points at up to 10 per cycle, pausing to drain so pending never saturates.
  task automatic add_pts(input int n);
    int rem;
    int c;
    int wv;
    int k;
    logic r;
    logic [5:0] m;
    rem = n;
    k = 0;
    while (rem > 0) begin
      c = (rem > 10) ? 10 : rem;
      if (c >= 5) begin
        r = 1'b1;
        wv = c - 5;
      end else begin
        r = 1'b0;
        wv = c;
      end
      m = (6'd1 << wv) - 6'd1;
      hit_cycle(m[4:0], r);
      rem -= c;
      k++;
      if (k % 20 == 0) wait_idle(400);
    end
    wait_idle(400);
  endtask

  initial begin
    int cnt;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    clear = 1'b0;
    hit_w_enemy = '0;
    hit_r_enemy = 1'b0;

    vecs[0] = '{5'b00000, 1'b0, 0,  16'h0000};
    vecs[1] = '{5'b00001, 1'b0, 1,  16'h0001};
    vecs[2] = '{5'b10101, 1'b1, 8,  16'h0008};
    vecs[3] = '{5'b11111, 1'b0, 5,  16'h0005};
    vecs[4] = '{5'b11111, 1'b1, 10, 16'h0010};
    vecs[5] = '{5'b00000, 1'b1, 5,  16'h0005};
    vecs[6] = '{5'b01010, 1'b0, 2,  16'h0002};

    step();
    step();
    rst = 1'b0;
    chk("reset_bin", int'(score_bin), 0);
    chk("reset_bcd", int'(score_bcd), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_sat", int'(sat), 0);
    chk("reset_speed", int'(speed_level), 5);
    chk("reset_hiscore", int'(hiscore_bcd), 0);

    for (int i = 0; i < 7; i++) begin
      do_clear();
      hit_cycle(vecs[i].w, vecs[i].r);
      chk($sformatf("vec%0d_bin", i), int'(score_bin), vecs[i].exp_bin);
      wait_idle(50);
      chk($sformatf("vec%0d_bcd", i), int'(score_bcd), int'(vecs[i].exp_bcd));
      chk($sformatf("vec%0d_speed", i), int'(speed_level), 5);
    end

    // Busy length for an 8-point hit.
    do_clear();
    hit_cycle(5'b10101, 1'b1);
    chk("busy8_bin", int'(score_bin), 8);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) cnt++;
      step();
    end
    chk("busy8_cycles", cnt, 8);
    chk("busy8_bcd", int'(score_bcd), 16'h0008);
    chk("busy8_busy", int'(busy), 0);

    // clear beats simultaneous hits.
    hit_w_enemy = 5'b11111;
    hit_r_enemy = 1'b1;
    do_clear();
    hit_w_enemy = '0;
    hit_r_enemy = 1'b0;
    chk("clear_wins_bin", int'(score_bin), 0);
    chk("clear_wins_busy", int'(busy), 0);
    chk("clear_wins_bcd", int'(score_bcd), 0);

    // Continuous hits while draining.
    for (int i = 0; i < 20; i++) hit_cycle(5'b00001, 1'b0);
    chk("stream_busy", int'(busy), 1);
    wait_idle(50);
    chk("stream_bin", int'(score_bin), 20);
    chk("stream_bcd", int'(score_bcd), 16'h0020);

    // rst aborts a drain with pending=7.
    do_clear();
    hit_cycle(5'b11111, 1'b1);
    step();
    step();
    step();
    chk("premrst_busy", int'(busy), 1);
    do_rst();
    chk("midrst_bin", int'(score_bin), 0);
    chk("midrst_bcd", int'(score_bcd), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_sat", int'(sat), 0);
    chk("midrst_speed", int'(speed_level), 5);
    step();
    step();
    step();
    chk("midrst_bcd_hold", int'(score_bcd), 0);
    chk("midrst_busy_hold", int'(busy), 0);

    // Speed-level thresholds.
    do_clear();
    add_pts(99);
    chk("s99_bcd", int'(score_bcd), 16'h0099);
    hit_cycle(5'b00001, 1'b0);
    chk("s100_bin", int'(score_bin), 100);
    chk("s100_speed_lag", int'(speed_level), 5);
    step();
    chk("s100_speed", int'(speed_level), 4);
    wait_idle(50);
    add_pts(399);
    chk("s499_speed", int'(speed_level), 4);
    hit_cycle(5'b00001, 1'b0);
    chk("s500_bin", int'(score_bin), 500);
    step();
    chk("s500_speed", int'(speed_level), 3);
    wait_idle(50);
    add_pts(4499);
    chk("s4999_bcd", int'(score_bcd), 16'h4999);
    chk("s4999_speed", int'(speed_level), 2);
    hit_cycle(5'b00001, 1'b0);
    chk("s5000_bin", int'(score_bin), 5000);
    step();
    chk("s5000_speed", int'(speed_level), 1);
    wait_idle(50);

    // Saturation.
    add_pts(4998);
    chk("s9998_bcd", int'(score_bcd), 16'h9998);
    chk("s9998_sat", int'(sat), 0);
    hit_cycle(5'b00000, 1'b1);
    chk("s9999_bin", int'(score_bin), 9999);
    chk("s9999_sat", int'(sat), 1);
    step();
    step();
    chk("s9999_bcd", int'(score_bcd), 16'h9999);
    chk("s9999_busy", int'(busy), 0);
    hit_cycle(5'b11111, 1'b1);
    chk("satmore_bin", int'(score_bin), 9999);
    chk("satmore_sat", int'(sat), 1);
    step();
    chk("satmore_bcd", int'(score_bcd), 16'h9999);
    chk("satmore_busy", int'(busy), 0);

`ifdef SCORE_HISCORE_EN
    do_rst();
    chk("hi_rst0", int'(hiscore_bcd), 0);
    add_pts(42);
    step();
    chk("hi_42", int'(hiscore_bcd), 16'h0042);
    do_clear();
    add_pts(10);
    step();
    chk("hi_after_clear_bcd", int'(score_bcd), 16'h0010);
    chk("hi_kept", int'(hiscore_bcd), 16'h0042);
    do_rst();
    chk("hi_rst", int'(hiscore_bcd), 0);
`else
    chk("hi_tied0", int'(hiscore_bcd), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
